sc_phase_gen: RTL and testbench

Two-phase non-overlapping clock generator that produces the `phi1`/`phi2` switch controls for the switched-capacitor filter stage, which sits directly downstream. From one system clock it derives programmable-width phases separated by a guaranteed dead time, so that no filter sampling switch pair is ever closed simultaneously. It also emits a per-period strobe and a period counter that downstream sampling logic consumes.

---
 rtl/sc_phase_gen.sv | 178 +++++++++++++++++
 tb/tb_sc_phase_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_phase_gen.sv
// -----------------------------------------------------------------------------
// sc_phase_gen
//
// Two-phase non-overlapping clock generator. It drives the phi1/phi2 switch
// controls of the switched-capacitor filter stage. Each period runs
//   phi1 (Pe cycles) -> dead (De) -> phi2 (Pe) -> dead (De)
// where Pe = max(phase_len, 1) and De = max(dead_len, 1). The dead time is
// never zero, so the two phases can never overlap.
//
// Parameters
//   CNT_W       width of the phase and dead-time length fields
//   PCNT_W      width of the completed-period counter
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   rst         synchronous, active-high reset
//   en          run request; level-sensitive. Dropping it lets the current
//               period finish before the generator goes idle.
//   phase_len   width of each phase in clk cycles (0 is treated as 1)
//   dead_len    non-overlap gap after each phase (0 is treated as 1)
//   phi1        phase-1 switch control, registered
//   phi2        phase-2 switch control, registered
//   busy        high while the generator is not idle, registered
//   period_done one-cycle pulse on the final dead cycle of each period
//   period_cnt  number of completed periods; wraps
//
// All outputs are registered decodes of the current state, so they appear
// one cycle after the state itself. This keeps phi1/phi2 glitch-free.
// Because every output takes the same one-cycle delay, the waveforms keep
// their relative timing.
// -----------------------------------------------------------------------------
module sc_phase_gen #(
    parameter int CNT_W  = 8,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  phase_len,
    input  logic [CNT_W-1:0]  dead_len,
    output logic              phi1,
    output logic              phi2,
    output logic              busy,
    output logic              period_done,
    output logic [PCNT_W-1:0] period_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PHI1,
        S_DEAD1,
        S_PHI2,
        S_DEAD2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  phase_sh, phase_sh_nxt;   // effective Pe for this period
    logic [CNT_W-1:0]  dead_sh, dead_sh_nxt;     // effective De for this period
    logic              expiry;
    logic              period_end;

    // Converts a programmed length into the effective length. A zero length
    // becomes one cycle, which is what guarantees a non-zero dead time.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    assign expiry     = (cnt == '0);
    assign period_end = (state == S_DEAD2) && expiry;

    // Next-state, counter reload and shadow capture.
    // The live length inputs are read only when a new period starts. That
    // point is reached from IDLE or from DEAD2. At all other times the
    // shadows are used, so a reprogram never stretches or shortens a phase
    // that has already begun.
    always_comb begin
        // NOTE: every signal this block assigns gets a default first, so
        // no path can leave a value unassigned and infer a latch.
        state_nxt    = state;
        cnt_nxt      = cnt;
        phase_sh_nxt = phase_sh;
        dead_sh_nxt  = dead_sh;

        unique case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt    = S_PHI1;
                    phase_sh_nxt = eff_len(phase_len);
                    dead_sh_nxt  = eff_len(dead_len);
                    cnt_nxt      = eff_len(phase_len) - CNT_W'(1);
                end
            end

            S_PHI1: begin
                if (expiry) begin
                    state_nxt = S_DEAD1;
                    cnt_nxt   = dead_sh - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_DEAD1: begin
                if (expiry) begin
                    state_nxt = S_PHI2;
                    cnt_nxt   = phase_sh - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_PHI2: begin
                if (expiry) begin
                    state_nxt = S_DEAD2;
                    cnt_nxt   = dead_sh - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_DEAD2: begin
                if (expiry) begin
                    // The period is complete in either case. en only decides
                    // whether another period follows without a gap.
                    if (en) begin
                        state_nxt    = S_PHI1;
                        phase_sh_nxt = eff_len(phase_len);
                        dead_sh_nxt  = eff_len(dead_len);
                        cnt_nxt      = eff_len(phase_len) - CNT_W'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register and registered Moore outputs. phi1 and phi2 decode a
    // single state register, so they are never high in the same cycle.
    // Reset clears both together, which keeps that true across reset too.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before this edge.
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            phase_sh    <= CNT_W'(1);
            dead_sh     <= CNT_W'(1);
            phi1        <= 1'b0;
            phi2        <= 1'b0;
            busy        <= 1'b0;
            period_done <= 1'b0;
            period_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            phase_sh    <= phase_sh_nxt;
            dead_sh     <= dead_sh_nxt;
            phi1        <= (state == S_PHI1);
            phi2        <= (state == S_PHI2);
            busy        <= (state != S_IDLE);
            period_done <= period_end;
            if (period_end) begin
                period_cnt <= period_cnt + PCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sc_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_sc_phase_gen
//
// Scoreboard bench for sc_phase_gen. For each period the stimulus code pushes
// the expected waveform, one entry per clock cycle. That waveform is
// (Pe phi1, De dead, Pe phi2, De dead). Each clock edge pops one entry and
// compares it with the DUT outputs. A separate process checks on every
// cycle that phi1 and phi2 are never high together.
// The DUT uses PCNT_W=4 so that the period counter wrap can be reached.
// -----------------------------------------------------------------------------
module tb_sc_phase_gen;

    localparam int CNT_W  = 8;
    localparam int PCNT_W = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic [CNT_W-1:0]  phase_len;
    logic [CNT_W-1:0]  dead_len;
    logic              phi1;
    logic              phi2;
    logic              busy;
    logic              period_done;
    logic [PCNT_W-1:0] period_cnt;

    typedef struct {
        logic              phi1;
        logic              phi2;
        logic              busy;
        logic              pdone;
        logic [PCNT_W-1:0] pcnt;
    } vec_t;

    vec_t              exp_q[$];
    logic [PCNT_W-1:0] exp_cnt;
    int                n_tests;
    int                n_fail;

    sc_phase_gen #(
        .CNT_W  (CNT_W),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .phase_len   (phase_len),
        .dead_len    (dead_len),
        .phi1        (phi1),
        .phi2        (phi2),
        .busy        (busy),
        .period_done (period_done),
        .period_cnt  (period_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Non-overlap must hold in every cycle, including during reset.
    always @(negedge clk) begin
        check("overlap", 32'(phi1 & phi2), 32'd0);
    end

    task automatic push_idle(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.phi1  = 1'b0;
            v.phi2  = 1'b0;
            v.busy  = 1'b0;
            v.pdone = 1'b0;
            v.pcnt  = exp_cnt;
            exp_q.push_back(v);
        end
    endtask

    // Pushes the expected waveform for one full period with effective
    // lengths pe and de.
    task automatic push_period(input int pe, input int de);
        vec_t v;
        int   len;
        len = 2 * (pe + de);
        for (int i = 0; i < len; i++) begin
            v.phi1  = (i < pe);
            v.phi2  = (i >= pe + de) && (i < 2 * pe + de);
            v.busy  = 1'b1;
            v.pdone = (i == len - 1);
            if (i == len - 1) exp_cnt = exp_cnt + 1'b1;
            v.pcnt  = exp_cnt;
            exp_q.push_back(v);
        end
    endtask

    task automatic tick();
        vec_t v;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("q_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            v = exp_q.pop_front();
            check("phi1", 32'(phi1), 32'(v.phi1));
            check("phi2", 32'(phi2), 32'(v.phi2));
            check("busy", 32'(busy), 32'(v.busy));
            check("period_done", 32'(period_done), 32'(v.pdone));
            check("period_cnt", 32'(period_cnt), 32'(v.pcnt));
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        rst       = 1'b1;
        en        = 1'b0;
        phase_len = 8'd3;
        dead_len  = 8'd1;

        // Reset state
        push_idle(2);
        tick_n(2);
        rst = 1'b0;
        push_idle(2);
        tick_n(2);

        // Basic pattern P=3 D=1. Four back-to-back periods, then a stop.
        en = 1'b1;
        push_idle(1);                         // start latency cycle
        for (int k = 0; k < 3; k++) push_period(3, 1);
        tick_n(1 + 24);
        push_period(3, 1);
        tick_n(7);
        en = 1'b0;                            // low before the last DEAD2 edge
        tick_n(1);
        push_idle(2);
        tick_n(2);

        // Clamping: P=0 and D=0 behave as P=1 and D=1.
        phase_len = 8'd0;
        dead_len  = 8'd0;
        en = 1'b1;
        push_idle(1);
        for (int k = 0; k < 3; k++) push_period(1, 1);
        tick_n(1 + 12);
        push_period(1, 1);
        tick_n(3);
        en = 1'b0;
        tick_n(1);
        push_idle(2);
        tick_n(2);

        // Graceful stop: P=4 D=2, en dropped on the 2nd phi1 cycle.
        phase_len = 8'd4;
        dead_len  = 8'd2;
        en = 1'b1;
        push_idle(1);
        push_period(4, 2);
        tick_n(3);                            // idle + two phi1 cycles
        en = 1'b0;
        tick_n(10);
        push_idle(4);
        tick_n(4);

        // Mid-period reprogram: P changes from 2 to 5 during PHI2.
        phase_len = 8'd2;
        dead_len  = 8'd1;
        en = 1'b1;
        push_idle(1);
        push_period(2, 1);
        tick_n(1 + 3 + 1);                    // up to the first phi2 cycle
        phase_len = 8'd5;
        tick_n(2);                            // current PHI2 stays at 2
        push_period(5, 1);
        tick_n(11);
        en = 1'b0;
        tick_n(1);
        push_idle(2);
        tick_n(2);

        // Reset mid-phase: P=6. rst on the 3rd phi2 cycle, en still high.
        phase_len = 8'd6;
        dead_len  = 8'd1;
        en = 1'b1;
        push_idle(1);
        push_period(6, 1);
        tick_n(1 + 7 + 3);
        rst = 1'b1;                           // reset wins over en
        exp_q.delete();
        exp_cnt = '0;
        push_idle(1);
        tick_n(1);
        rst = 1'b0;
        push_idle(1);                         // en sampled in IDLE
        push_period(6, 1);
        tick_n(1 + 13);
        en = 1'b0;
        tick_n(1);
        push_idle(2);
        tick_n(2);

        // Counter wrap: 16 periods of P=1 D=1, so the count passes 15 -> 0.
        phase_len = 8'd1;
        dead_len  = 8'd1;
        en = 1'b1;
        push_idle(1);
        for (int k = 0; k < 16; k++) push_period(1, 1);
        tick_n(1 + 63);
        en = 1'b0;
        tick_n(1);
        push_idle(2);
        tick_n(2);

        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
